// File: rtl/axis_perf_monitor_mc.sv
// Multi-channel AXI-Stream performance monitor: passively taps NUM_CH
// streams and counts beats, packets, bytes and malformed-tkeep beats over
// a start/stop or fixed-length measurement window.
module axis_perf_monitor_mc #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned TDATA_WIDTH = 512,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                                           CLK,
    input  logic                                           RST_N,
    input  logic [NUM_CH-1:0]                              mon_tvalid,
    input  logic [NUM_CH-1:0]                              mon_tready,
    input  logic [NUM_CH-1:0]                              mon_tlast,
    input  logic [NUM_CH*(TDATA_WIDTH/8)-1:0]              mon_tkeep,
    input  logic                                           start,
    input  logic                                           stop,
    input  logic                                           clear,
    input  logic [CNT_WIDTH-1:0]                           window_cycles,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_sel,
    output logic [1:0]                                     state,
    output logic [CNT_WIDTH-1:0]                           cycle_count,
    output logic [CNT_WIDTH-1:0]                           rd_beat,
    output logic [CNT_WIDTH-1:0]                           rd_pkt,
    output logic [CNT_WIDTH-1:0]                           rd_byte,
    output logic [CNT_WIDTH-1:0]                           rd_err,
    output logic                                           rd_sat,
    output logic                                           cycle_sat
);

    localparam int unsigned TKEEP_WIDTH = TDATA_WIDTH / 8;
    localparam int unsigned SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PC_W        = $clog2(TKEEP_WIDTH + 1);
    localparam int unsigned SUM_W       = ((CNT_WIDTH > PC_W) ? CNT_WIDTH : PC_W) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_zero;
    logic                  w_latch;
    logic                  w_count_en;
    logic                  w_end;
    logic [NUM_CH-1:0]     w_hit;
    logic [CNT_WIDTH-1:0]  w_cyc_next;
    logic [CNT_WIDTH-1:0]  r_cyc;
    logic                  r_cyc_sat;
    logic [CNT_WIDTH-1:0]  r_win;

    logic [CNT_WIDTH-1:0]  r_beat [NUM_CH];
    logic [CNT_WIDTH-1:0]  r_pkt  [NUM_CH];
    logic [CNT_WIDTH-1:0]  r_byte [NUM_CH];
    logic [CNT_WIDTH-1:0]  r_err  [NUM_CH];
    logic [NUM_CH-1:0]     r_sat;

    logic [CNT_WIDTH-1:0]  w_beat_n [NUM_CH];
    logic [CNT_WIDTH-1:0]  w_pkt_n  [NUM_CH];
    logic [CNT_WIDTH-1:0]  w_byte_n [NUM_CH];
    logic [CNT_WIDTH-1:0]  w_err_n  [NUM_CH];
    logic [NUM_CH-1:0]     w_sat_n;

    logic [CNT_WIDTH-1:0]  w_rd_beat, w_rd_pkt, w_rd_byte, w_rd_err;
    logic                  w_rd_sat;
    logic [CNT_WIDTH-1:0]  r_rd_beat, r_rd_pkt, r_rd_byte, r_rd_err;
    logic                  r_rd_sat;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + CNT_WIDTH'(1);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] v,
                                                     input logic [PC_W-1:0]      n);
        logic [SUM_W-1:0] s;
        s = SUM_W'(v) + SUM_W'(n);
        return (s > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_WIDTH'(s);
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [TKEEP_WIDTH-1:0] k);
        logic [PC_W-1:0] c;
        c = '0;
        for (int j = 0; j < TKEEP_WIDTH; j++) c = c + PC_W'(k[j]);
        return c;
    endfunction

    // Non-last beats must be full; last beats must be a non-empty low-aligned mask.
    function automatic logic keep_err(input logic last, input logic [TKEEP_WIDTH-1:0] k);
        logic [TKEEP_WIDTH-1:0] p1;
        p1 = k + TKEEP_WIDTH'(1);
        if (last) return (k == '0) || ((k & p1) != '0);
        return k != {TKEEP_WIDTH{1'b1}};
    endfunction

    assign w_hit      = mon_tvalid & mon_tready;
    assign w_cyc_next = sat_inc(r_cyc);
    assign w_end      = ((r_win != '0) && (w_cyc_next == r_win)) || (w_cyc_next == CNT_MAX);

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next state and counter controls; clear beats start beats stop.
    always_comb begin
        w_state_next = r_state;
        w_zero       = 1'b0;
        w_latch      = 1'b0;
        w_count_en   = 1'b0;
        if (clear) begin
            w_state_next = S_IDLE;
            w_zero       = 1'b1;
        end else if (start && (r_state == S_IDLE || r_state == S_DONE)) begin
            w_state_next = S_ARMED;
            w_zero       = 1'b1;
            w_latch      = 1'b1;
        end else begin
            case (r_state)
                S_ARMED: begin
                    if (stop) begin
                        w_state_next = S_DONE;
                    end else if (|w_hit) begin
                        w_count_en   = 1'b1;
                        w_state_next = w_end ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_count_en   = 1'b1;
                        w_state_next = w_end ? S_DONE : S_RUN;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    // Cycle counter, its saturation flag and the latched window length.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cyc     <= '0;
            r_cyc_sat <= 1'b0;
            r_win     <= '0;
        end else if (w_zero) begin
            r_cyc     <= '0;
            r_cyc_sat <= 1'b0;
            r_win     <= w_latch ? window_cycles : '0;
        end else if (w_count_en) begin
            r_cyc     <= w_cyc_next;
            r_cyc_sat <= r_cyc_sat | (w_cyc_next == CNT_MAX);
        end
    end

    // Per-channel saturating next values for a counted beat.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_beat_n[i] = sat_inc(r_beat[i]);
            w_pkt_n[i]  = mon_tlast[i] ? sat_inc(r_pkt[i]) : r_pkt[i];
            w_byte_n[i] = sat_add(r_byte[i], popcount(mon_tkeep[i*TKEEP_WIDTH +: TKEEP_WIDTH]));
            w_err_n[i]  = keep_err(mon_tlast[i], mon_tkeep[i*TKEEP_WIDTH +: TKEEP_WIDTH])
                          ? sat_inc(r_err[i]) : r_err[i];
            w_sat_n[i]  = r_sat[i] | (w_beat_n[i] == CNT_MAX) | (w_pkt_n[i] == CNT_MAX)
                          | (w_byte_n[i] == CNT_MAX) | (w_err_n[i] == CNT_MAX);
        end
    end

    // Per-channel counters and sticky saturation flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sat <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_beat[i] <= '0;
                r_pkt[i]  <= '0;
                r_byte[i] <= '0;
                r_err[i]  <= '0;
            end
        end else if (w_zero) begin
            r_sat <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_beat[i] <= '0;
                r_pkt[i]  <= '0;
                r_byte[i] <= '0;
                r_err[i]  <= '0;
            end
        end else if (w_count_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_hit[i]) begin
                    r_beat[i] <= w_beat_n[i];
                    r_pkt[i]  <= w_pkt_n[i];
                    r_byte[i] <= w_byte_n[i];
                    r_err[i]  <= w_err_n[i];
                    r_sat[i]  <= w_sat_n[i];
                end
            end
        end
    end

    // Readout mux; unmatched selects read as zero.
    always_comb begin
        w_rd_beat = '0;
        w_rd_pkt  = '0;
        w_rd_byte = '0;
        w_rd_err  = '0;
        w_rd_sat  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                w_rd_beat = r_beat[i];
                w_rd_pkt  = r_pkt[i];
                w_rd_byte = r_byte[i];
                w_rd_err  = r_err[i];
                w_rd_sat  = r_sat[i];
            end
        end
    end

    // Readout register, one cycle behind rd_sel and the counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rd_beat <= '0;
            r_rd_pkt  <= '0;
            r_rd_byte <= '0;
            r_rd_err  <= '0;
            r_rd_sat  <= 1'b0;
        end else begin
            r_rd_beat <= w_rd_beat;
            r_rd_pkt  <= w_rd_pkt;
            r_rd_byte <= w_rd_byte;
            r_rd_err  <= w_rd_err;
            r_rd_sat  <= w_rd_sat;
        end
    end

    assign state       = r_state;
    assign cycle_count = r_cyc;
    assign cycle_sat   = r_cyc_sat;
    assign rd_beat     = r_rd_beat;
    assign rd_pkt      = r_rd_pkt;
    assign rd_byte     = r_rd_byte;
    assign rd_err      = r_rd_err;
    assign rd_sat      = r_rd_sat;

endmodule

// File: tb/tb_axis_perf_monitor_mc.sv
// Directed bench for axis_perf_monitor_mc: a default instance (2 ch, 512b,
// 32-bit counters) and a small one (3 ch, 32b, 4-bit counters) for saturation.
module tb_axis_perf_monitor_mc;

    logic         CLK;
    logic         RST_N;

    // Default instance
    logic [1:0]   tvalid, tready, tlast;
    logic [127:0] tkeep;
    logic         start, stop, clear;
    logic [31:0]  window;
    logic [0:0]   rd_sel;
    logic [1:0]   state;
    logic [31:0]  cycle_count, rd_beat, rd_pkt, rd_byte, rd_err;
    logic         rd_sat, cycle_sat;

    // Small instance
    logic [2:0]   s_tvalid, s_tready, s_tlast;
    logic [11:0]  s_tkeep;
    logic         s_start, s_stop, s_clear;
    logic [3:0]   s_window;
    logic [1:0]   s_rd_sel;
    logic [1:0]   s_state;
    logic [3:0]   s_cycle_count, s_rd_beat, s_rd_pkt, s_rd_byte, s_rd_err;
    logic         s_rd_sat, s_cycle_sat;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [63:0] FULL = 64'hFFFF_FFFF_FFFF_FFFF;

    axis_perf_monitor_mc #(.NUM_CH(2), .TDATA_WIDTH(512), .CNT_WIDTH(32)) u_dut (
        .CLK(CLK), .RST_N(RST_N),
        .mon_tvalid(tvalid), .mon_tready(tready), .mon_tlast(tlast), .mon_tkeep(tkeep),
        .start(start), .stop(stop), .clear(clear), .window_cycles(window), .rd_sel(rd_sel),
        .state(state), .cycle_count(cycle_count),
        .rd_beat(rd_beat), .rd_pkt(rd_pkt), .rd_byte(rd_byte), .rd_err(rd_err),
        .rd_sat(rd_sat), .cycle_sat(cycle_sat)
    );

    axis_perf_monitor_mc #(.NUM_CH(3), .TDATA_WIDTH(32), .CNT_WIDTH(4)) u_dut_s (
        .CLK(CLK), .RST_N(RST_N),
        .mon_tvalid(s_tvalid), .mon_tready(s_tready), .mon_tlast(s_tlast), .mon_tkeep(s_tkeep),
        .start(s_start), .stop(s_stop), .clear(s_clear), .window_cycles(s_window), .rd_sel(s_rd_sel),
        .state(s_state), .cycle_count(s_cycle_count),
        .rd_beat(s_rd_beat), .rd_pkt(s_rd_pkt), .rd_byte(s_rd_byte), .rd_err(s_rd_err),
        .rd_sat(s_rd_sat), .cycle_sat(s_cycle_sat)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] l,
                         input logic [63:0] k0, input logic [63:0] k1);
        tvalid = v;
        tready = v;
        tlast  = l;
        tkeep  = {k1, k0};
    endtask

    task automatic ctrl(input logic st, input logic sp, input logic cl);
        start = st;
        stop  = sp;
        clear = cl;
    endtask

    initial begin
        RST_N = 1'b0;
        drive(2'b00, 2'b00, 64'd0, 64'd0);
        ctrl(1'b0, 1'b0, 1'b0);
        window = 32'd0;
        rd_sel = 1'b0;
        s_tvalid = '0; s_tready = '0; s_tlast = '0; s_tkeep = '0;
        s_start = 1'b0; s_stop = 1'b0; s_clear = 1'b0; s_window = '0; s_rd_sel = '0;

        // Reset state
        #2;
        check("rst_state", state, 0);
        check("rst_cycle", cycle_count, 0);
        check("rst_rd_beat", rd_beat, 0);
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        check("idle_state", state, 0);

        // Windowed run: 3 packets of 2 full beats on ch0, window 10
        window = 32'd10;
        ctrl(1'b1, 1'b0, 1'b0);
        tick();
        check("w_armed", state, 1);
        ctrl(1'b0, 1'b0, 1'b0);
        tick();
        check("w_still_armed", state, 1);
        for (int i = 0; i < 6; i++) begin
            drive(2'b01, (i % 2 == 1) ? 2'b01 : 2'b00, FULL, 64'd0);
            tick();
            if (i == 0) begin
                check("w_first_state", state, 2);
                check("w_first_cycle", cycle_count, 1);
            end
        end
        drive(2'b00, 2'b00, 64'd0, 64'd0);
        for (int i = 0; i < 3; i++) tick();
        check("w_c9_state", state, 2);
        check("w_c9_cycle", cycle_count, 9);
        tick();
        check("w_done_state", state, 3);
        check("w_done_cycle", cycle_count, 10);
        tick();
        check("w_hold_cycle", cycle_count, 10);
        rd_sel = 1'b0;
        tick();
        check("w_beat", rd_beat, 6);
        check("w_pkt", rd_pkt, 3);
        check("w_byte", rd_byte, 384);
        check("w_err", rd_err, 0);
        check("w_sat", rd_sat, 0);
        check("w_cycle_sat", cycle_sat, 0);

        // tkeep error classification on ch1, with a concurrent beat on ch0
        window = 32'd0;
        ctrl(1'b1, 1'b0, 1'b0);
        tick();
        check("k_armed", state, 1);
        ctrl(1'b0, 1'b0, 1'b0);
        drive(2'b11, 2'b11, FULL, 64'h00FF);
        tick();
        drive(2'b10, 2'b10, 64'd0, 64'h0F0F);
        tick();
        drive(2'b10, 2'b00, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        drive(2'b10, 2'b10, 64'd0, FULL);
        tick();
        drive(2'b00, 2'b00, 64'd0, 64'd0);
        ctrl(1'b0, 1'b1, 1'b0);
        tick();
        ctrl(1'b0, 1'b0, 1'b0);
        check("k_done", state, 3);
        check("k_cycle", cycle_count, 4);
        rd_sel = 1'b1;
        tick();
        check("k1_beat", rd_beat, 4);
        check("k1_pkt", rd_pkt, 3);
        check("k1_byte", rd_byte, 143);
        check("k1_err", rd_err, 2);
        rd_sel = 1'b0;
        check("k_rd_latency", rd_beat, 4);
        tick();
        check("k0_beat", rd_beat, 1);
        check("k0_byte", rd_byte, 64);
        check("k0_pkt", rd_pkt, 1);
        ctrl(1'b0, 1'b1, 1'b0);
        tick();
        ctrl(1'b0, 1'b0, 1'b0);
        check("k_stop_in_done", state, 3);

        // Unlimited window, 100 counted cycles, stop cycle carries a beat
        ctrl(1'b1, 1'b0, 1'b0);
        tick();
        ctrl(1'b0, 1'b0, 1'b0);
        drive(2'b01, 2'b00, FULL, 64'd0);
        for (int i = 0; i < 100; i++) begin
            start = (i == 50);
            tick();
        end
        start = 1'b0;
        check("u_run_state", state, 2);
        check("u_run_cycle", cycle_count, 100);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drive(2'b00, 2'b00, 64'd0, 64'd0);
        check("u_done", state, 3);
        check("u_cycle", cycle_count, 100);
        rd_sel = 1'b0;
        tick();
        check("u_beat", rd_beat, 100);
        check("u_byte", rd_byte, 6400);
        check("u_err", rd_err, 0);

        // Control priority and ignored commands
        ctrl(1'b1, 1'b0, 1'b0);
        tick();
        check("p_armed", state, 1);
        tick();
        check("p_start_in_armed", state, 1);
        ctrl(1'b0, 1'b0, 1'b0);
        drive(2'b01, 2'b01, FULL, 64'd0);
        tick();
        tick();
        check("p_run", state, 2);
        check("p_run_cycle", cycle_count, 2);
        ctrl(1'b1, 1'b1, 1'b1);
        tick();
        ctrl(1'b0, 1'b0, 1'b0);
        drive(2'b00, 2'b00, 64'd0, 64'd0);
        check("p_clear_state", state, 0);
        check("p_clear_cycle", cycle_count, 0);
        tick();
        check("p_clear_beat", rd_beat, 0);
        check("p_clear_byte", rd_byte, 0);
        stop = 1'b1;
        tick();
        check("p_stop_in_idle", state, 0);
        ctrl(1'b1, 1'b0, 1'b0);
        tick();
        ctrl(1'b0, 1'b1, 1'b0);
        tick();
        ctrl(1'b0, 1'b0, 1'b0);
        check("p_armed_stop", state, 3);
        check("p_armed_stop_cycle", cycle_count, 0);
        tick();
        check("p_armed_stop_beat", rd_beat, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("p_clear_done", state, 0);

        // Asynchronous reset in the middle of a run
        ctrl(1'b1, 1'b0, 1'b0);
        tick();
        ctrl(1'b0, 1'b0, 1'b0);
        drive(2'b01, 2'b00, FULL, 64'd0);
        tick();
        tick();
        tick();
        check("r_pre_cycle", cycle_count, 3);
        check("r_pre_rd_beat", rd_beat, 2);
        #3;
        RST_N = 1'b0;
        #1;
        check("r_async_state", state, 0);
        check("r_async_cycle", cycle_count, 0);
        check("r_async_rd_beat", rd_beat, 0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        tick();
        check("r_release_state", state, 0);
        check("r_release_cycle", cycle_count, 0);
        drive(2'b00, 2'b00, 64'd0, 64'd0);
        tick();
        check("r_release_beat", rd_beat, 0);
        window = 32'd5;
        ctrl(1'b1, 1'b0, 1'b0);
        tick();
        ctrl(1'b0, 1'b0, 1'b0);
        drive(2'b01, 2'b00, FULL, 64'd0);
        for (int i = 0; i < 5; i++) tick();
        drive(2'b00, 2'b00, 64'd0, 64'd0);
        check("r_new_done", state, 3);
        check("r_new_cycle", cycle_count, 5);
        tick();
        check("r_new_beat", rd_beat, 5);
        check("r_new_byte", rd_byte, 320);

        // Saturation on the 4-bit instance
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("s_armed", s_state, 1);
        s_tready = 3'b111;
        for (int i = 0; i < 20; i++) begin
            s_tvalid = (i == 0) ? 3'b101 : 3'b001;
            s_tlast  = (i == 0) ? 3'b100 : 3'b000;
            s_tkeep  = 12'h10F;
            tick();
        end
        s_tvalid = '0;
        s_tready = '0;
        s_tlast  = '0;
        s_tkeep  = '0;
        check("s_done", s_state, 3);
        check("s_cycle", s_cycle_count, 15);
        check("s_cycle_sat", s_cycle_sat, 1);
        s_rd_sel = 2'd0;
        tick();
        check("s0_beat", s_rd_beat, 15);
        check("s0_byte", s_rd_byte, 15);
        check("s0_sat", s_rd_sat, 1);
        check("s0_pkt", s_rd_pkt, 0);
        s_rd_sel = 2'd1;
        tick();
        check("s1_sat", s_rd_sat, 0);
        check("s1_beat", s_rd_beat, 0);
        s_rd_sel = 2'd2;
        tick();
        check("s2_beat", s_rd_beat, 1);
        check("s2_byte", s_rd_byte, 1);
        check("s2_pkt", s_rd_pkt, 1);
        check("s2_err", s_rd_err, 0);
        s_rd_sel = 2'd3;
        tick();
        check("s3_oob_beat", s_rd_beat, 0);
        check("s3_oob_byte", s_rd_byte, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
